bcd_converter_seq: RTL and testbench

Sequential binary-to-BCD converter using shift-and-add-3 (double dabble). It sits directly upstream of the 7-segment display multiplexer. It takes the binary counter value and delivers registered units/tens/hundreds digits plus a leading-zero mask. This replaces the combinational `%`/`/` digit extraction with a small multi-cycle datapath and a start/done handshake.

---
 rtl/bcd_pkg.sv | 8 +
 rtl/bcd_digit_adjust.sv | 10 +
 rtl/bcd_converter_seq.sv | 85 ++++++++
 tb/tb_bcd_converter_seq.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// bcd_pkg: shared constants for the double-dabble converter and the display stage
package bcd_pkg;
  localparam logic [0:0] IDLE        = 1'b0;
  localparam logic [0:0] SHIFT       = 1'b1;
  localparam logic [3:0] ADD3_THRESH = 4'd5;
  localparam logic [3:0] BCD_NINE    = 4'h9;
  localparam logic [3:0] BCD_BLANK   = 4'hF;
endpackage

// File: rtl/bcd_digit_adjust.sv
// bcd_digit_adjust: add-3 correction applied to one BCD digit before each shift
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);
  // 4-bit result; a carry into the neighbouring digit is impossible for digits 5..9
  always_comb digit_o = (digit_i >= ADD3_THRESH) ? digit_i + 4'd3 : digit_i;
endmodule

// File: rtl/bcd_converter_seq.sv
// bcd_converter_seq: multi-cycle binary-to-BCD converter with start/done handshake
module bcd_converter_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      bin_in,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     lz_mask,
  output logic                  overflow
);
  localparam int SW = 4*DIGITS + WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  logic [0:0]          state_q;
  logic [CW-1:0]       cnt_q;
  logic [SW-1:0]       sr_q, adj, sr_d;
  logic                ovf_q, ovf_d, ovf_out_q, done_q, last;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic [DIGITS-1:0]   lz_q, lz_d;

  assign adj[WIDTH-1:0] = sr_q[WIDTH-1:0];
  for (genvar k = 0; k < DIGITS; k++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit_i(sr_q[WIDTH+4*k +: 4]),
      .digit_o(adj[WIDTH+4*k +: 4])
    );
  end

  // next shift-register value, sticky overflow and the result that the final step commits
  always_comb begin
    sr_d  = {adj[SW-2:0], 1'b0};
    ovf_d = ovf_q | adj[SW-1];
    bcd_d = ovf_d ? {DIGITS{BCD_NINE}} : sr_d[SW-1:WIDTH];
    last  = cnt_q == CW'(WIDTH - 1);
    lz_d  = '0;
    for (int k = 1; k < DIGITS; k++) lz_d[k] = (bcd_d >> (4*k)) == '0;
  end

  // FSM, datapath and output registers; reset discards any conversion in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sr_q      <= '0;
      ovf_q     <= 1'b0;
      ovf_out_q <= 1'b0;
      done_q    <= 1'b0;
      bcd_q     <= '0;
      lz_q      <= ~DIGITS'(1);
    end else begin
      done_q <= 1'b0;
      if (state_q == IDLE) begin
        if (start) begin
          state_q <= SHIFT;
          sr_q    <= {{(4*DIGITS){1'b0}}, bin_in};
          cnt_q   <= '0;
          ovf_q   <= 1'b0;
        end
      end else begin
        sr_q  <= sr_d;
        ovf_q <= ovf_d;
        cnt_q <= cnt_q + CW'(1);
        if (last) begin
          state_q   <= IDLE;
          bcd_q     <= bcd_d;
          lz_q      <= lz_d;
          ovf_out_q <= ovf_d;
          done_q    <= 1'b1;
        end
      end
    end
  end

  assign busy     = state_q == SHIFT;
  assign done     = done_q;
  assign bcd_out  = bcd_q;
  assign lz_mask  = lz_q;
  assign overflow = ovf_out_q;
endmodule

// File: tb/tb_bcd_converter_seq.sv
// tb_bcd_converter_seq: directed and random checks of the converter at WIDTH=8 and WIDTH=10
module tb_bcd_converter_seq;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #10 clk = ~clk;

  logic [7:0]  bin8 = '0;
  logic [9:0]  bin10 = '0;
  logic        start8 = 1'b0, start10 = 1'b0;
  logic        busy8, done8, ovf8, busy10, done10, ovf10;
  logic [11:0] bcd8, bcd10;
  logic [2:0]  lz8, lz10;
  int tests = 0, fails = 0, dcnt8 = 0, dcnt10 = 0;

  bcd_converter_seq #(.WIDTH(8), .DIGITS(3)) u8 (
    .clk(clk), .rst(rst), .bin_in(bin8), .start(start8), .busy(busy8), .done(done8),
    .bcd_out(bcd8), .lz_mask(lz8), .overflow(ovf8));
  bcd_converter_seq #(.WIDTH(10), .DIGITS(3)) u10 (
    .clk(clk), .rst(rst), .bin_in(bin10), .start(start10), .busy(busy10), .done(done10),
    .bcd_out(bcd10), .lz_mask(lz10), .overflow(ovf10));

  always @(negedge clk) begin
    if (done8) dcnt8++;
    if (done10) dcnt10++;
  end

  function automatic logic [11:0] ref_bcd(input int v);
    logic [11:0] r = '0;
    if (v > 999) return 12'h999;
    for (int i = 0; i < 3; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [2:0] ref_lz(input int v);
    if (v > 999) return 3'b000;
    return {v < 100, v < 10, 1'b0};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic run(input int sel, input int v);
    int cyc = 0;
    @(negedge clk);
    if (sel != 0) begin bin10 = v[9:0]; start10 = 1'b1; end
    else begin bin8 = v[7:0]; start8 = 1'b1; end
    @(negedge clk);
    start8 = 1'b0;
    start10 = 1'b0;
    while (!(sel != 0 ? done10 : done8) && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("latency", cyc, sel != 0 ? 10 : 8);
    check("busy_at_done", sel != 0 ? busy10 : busy8, 0);
    check("bcd", sel != 0 ? bcd10 : bcd8, ref_bcd(v));
    check("lz", sel != 0 ? lz10 : lz8, ref_lz(v));
    check("ovf", sel != 0 ? ovf10 : ovf8, (sel != 0 && v > 999) ? 1 : 0);
  endtask

  initial begin
    int base, cyc;
    repeat (2) @(negedge clk);
    check("rst_busy", busy8, 0);
    check("rst_done", done8, 0);
    check("rst_bcd", bcd8, 0);
    check("rst_lz", lz8, 3'b110);
    check("rst_ovf", ovf8, 0);
    rst = 1'b1;
    run(0, 0);
    run(0, 255);
    run(0, 7);
    run(0, 100);

    @(negedge clk);
    base = dcnt8;
    start8 = 1'b1;
    for (int i = 0; i < 256; i++) begin
      bin8 = 8'(i);
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (!done8 && cyc < 30);
      check("sweep_period", cyc, 9);
      check("sweep_bcd", bcd8, ref_bcd(i));
      check("sweep_lz", lz8, ref_lz(i));
    end
    start8 = 1'b0;
    @(negedge clk);
    check("sweep_done_count", dcnt8 - base, 256);

    @(negedge clk);
    base = dcnt8;
    bin8 = 8'd42;
    start8 = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      start8 = (c == 1 || c == 4);
      bin8 = start8 ? 8'd42 : 8'($urandom);
    end
    start8 = 1'b0;
    check("ignored_start_dones", dcnt8 - base, 1);
    check("ignored_start_bcd", bcd8, 12'h042);

    @(negedge clk);
    bin8 = 8'd200;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_busy", busy8, 0);
    check("midrst_done", done8, 0);
    check("midrst_bcd", bcd8, 0);
    check("midrst_lz", lz8, 3'b110);
    @(negedge clk);
    base = dcnt8;
    rst = 1'b1;
    repeat (15) @(negedge clk);
    check("no_done_after_rst", dcnt8 - base, 0);
    run(0, 13);

    run(1, 1000);
    run(1, 999);
    run(1, 1023);
    run(1, 0);
    for (int i = 0; i < 30; i++) begin
      run(0, int'($urandom_range(0, 255)));
      run(1, int'($urandom_range(0, 1023)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
